// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions (one per PC update).
module mc_control_unit #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 bcond,
    input  logic                 halt_cond,
    input  logic                 mem_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 i_or_d,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic                 pc_write,
    output logic [1:0]           pc_source,
    output logic [1:0]           mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 is_halted,
    output logic [CNT_WIDTH-1:0] retired_cnt
);

    // state  | meaning
    // S_IF   | fetch: read IR from memory at PC, wait for mem_ready
    // S_ID   | decode: ALUOut <= PC+imm, dispatch or retire NOP/ecall
    // S_EX   | execute: ALU op, branches and jumps retire here
    // S_MEM  | data access at ALUOut, wait for mem_ready
    // S_WB   | register writeback, retire
    // S_HALT | ecall halt, sticky until reset
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    state_t state;
    state_t state_next;
    logic   is_load;
    logic   is_exec;
    logic   is_ecall;

    assign is_load  = (opcode == OP_LOAD);
    assign is_ecall = (opcode == OP_ECALL);
    assign is_exec  = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                      (opcode == OP_STORE) || (opcode == OP_BR) || (opcode == OP_JAL) ||
                      (opcode == OP_JALR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IF;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IF: begin
                if (mem_ready) state_next = S_ID;
            end
            S_ID: begin
                if (is_ecall && halt_cond) state_next = S_HALT;
                else if (is_exec)          state_next = S_EX;
                else                       state_next = S_IF;
            end
            S_EX: begin
                if ((opcode == OP_R) || (opcode == OP_I))
                    state_next = S_WB;
                else if ((opcode == OP_LOAD) || (opcode == OP_STORE))
                    state_next = S_MEM;
                else
                    state_next = S_IF;
            end
            S_MEM: begin
                if (mem_ready) state_next = is_load ? S_WB : S_IF;
            end
            S_WB:    state_next = S_IF;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IF;
        endcase
    end

    // Everything is forced low while reset is held, including the fetch read.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        is_halted  = 1'b0;
        if (reset) begin
            case (state)
                S_IF: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                end
                S_ID: begin
                    alu_src_b = 2'b10;
                    if (!is_exec && !(is_ecall && halt_cond)) pc_write = 1'b1;
                end
                S_EX: begin
                    case (opcode)
                        OP_R: begin
                            alu_src_a = 1'b1;
                            alu_op    = 2'b10;
                        end
                        OP_I: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'b10;
                            alu_op    = 2'b10;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'b10;
                        end
                        OP_BR: begin
                            alu_src_a = 1'b1;
                            alu_op    = 2'b01;
                            pc_write  = 1'b1;
                            pc_source = bcond ? 2'b01 : 2'b00;
                        end
                        OP_JAL: begin
                            reg_write  = 1'b1;
                            mem_to_reg = 2'b10;
                            pc_write   = 1'b1;
                            pc_source  = 2'b01;
                        end
                        OP_JALR: begin
                            alu_src_a  = 1'b1;
                            alu_src_b  = 2'b10;
                            reg_write  = 1'b1;
                            mem_to_reg = 2'b10;
                            pc_write   = 1'b1;
                            pc_source  = 2'b10;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = is_load;
                    mem_write = !is_load;
                    pc_write  = mem_ready && !is_load;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = is_load ? 2'b01 : 2'b00;
                    pc_write   = 1'b1;
                end
                S_HALT:  is_halted = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_cnt <= '0;
        end else if (pc_write) begin
            retired_cnt <= retired_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
